// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Round-robin controller that shares one combinational ALU between two
// clients. A request is granted in IDLE. The winner's function select and
// operands are latched into registers that drive the ALU. The ALU gets one
// full EXEC cycle to settle. Its result is captured into the winner's result
// register, and the winner receives a one-cycle acknowledge in ACK.
//
// Ports:
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   req0/op0/a0/b0          : client 0 request (level), function, operands
//   ack0/res0               : client 0 completion pulse and held result
//   req1/op1/a1/b1          : client 1 request (level), function, operands
//   ack1/res1               : client 1 completion pulse and held result
//   alu_fun_sel/alu_a/alu_b : registered function select and operands to ALU
//   alu_f                   : combinational ALU result
//   busy                    : high whenever the FSM is not in IDLE
//   last_grant              : index of the most recently granted client
//   op_count                : completed-operation counter (wraps)
module alu_share_ctrl #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [1:0]    op0,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  b0,
  output logic          ack0,
  output logic [W-1:0]  res0,
  input  logic          req1,
  input  logic [1:0]    op1,
  input  logic [W-1:0]  a1,
  input  logic [W-1:0]  b1,
  output logic          ack1,
  output logic [W-1:0]  res1,
  output logic [1:0]    alu_fun_sel,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_f,
  output logic          busy,
  output logic          last_grant,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state_q;
  logic          gnt_q;
  logic          last_grant_q;
  logic          ack0_q, ack1_q;
  logic [W-1:0]  res0_q, res1_q;
  logic [1:0]    alu_fun_sel_q;
  logic [W-1:0]  alu_a_q, alu_b_q;
  logic [CW-1:0] op_count_q;

  // Arbitration result for the current IDLE cycle.
  logic          any_req_d;
  logic          win_d;
  logic [CW-1:0] op_count_d;

  always_comb begin
    any_req_d  = req0 | req1;
    // Tie goes to the client that did not win last time; otherwise the
    // single requester wins (req1 alone selects 1, req0 alone selects 0).
    win_d      = (req0 & req1) ? ~last_grant_q : req1;
    op_count_d = op_count_q + {{(CW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b1;  // client 0 wins the first tie
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      res0_q        <= '0;
      res1_q        <= '0;
      alu_fun_sel_q <= 2'b00;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      op_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q      <= EXEC;
            gnt_q        <= win_d;
            last_grant_q <= win_d;
            // Operands are frozen here; later client changes are ignored.
            if (win_d) begin
              alu_fun_sel_q <= op1;
              alu_a_q       <= a1;
              alu_b_q       <= b1;
            end else begin
              alu_fun_sel_q <= op0;
              alu_a_q       <= a0;
              alu_b_q       <= b0;
            end
          end
        end
        EXEC: begin
          // The ALU has settled for a full cycle; capture into the winner only.
          state_q <= ACK;
          if (gnt_q) begin
            res1_q <= alu_f;
            ack1_q <= 1'b1;
          end else begin
            res0_q <= alu_f;
            ack0_q <= 1'b1;
          end
        end
        ACK: begin
          state_q    <= IDLE;
          ack0_q     <= 1'b0;
          ack1_q     <= 1'b0;
          op_count_q <= op_count_d;
        end
        default: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign res0        = res0_q;
  assign res1        = res1_q;
  assign alu_fun_sel = alu_fun_sel_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign busy        = (state_q != IDLE);
  assign last_grant  = last_grant_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu_share_ctrl;
  localparam int W  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [1:0]    op0, op1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          ack0, ack1;
  logic [W-1:0]  res0, res1;
  logic [1:0]    alu_fun_sel;
  logic [W-1:0]  alu_a, alu_b;
  logic [W-1:0]  alu_f;
  logic          busy, last_grant;
  logic [CW-1:0] op_count;

  alu_share_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0), .res0(res0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1), .res1(res1),
    .alu_fun_sel(alu_fun_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .busy(busy), .last_grant(last_grant), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // The shared ALU that sits outside the controller.
  always_comb begin
    case (alu_fun_sel)
      2'b00:   alu_f = alu_a + alu_b;
      2'b01:   alu_f = alu_a - alu_b;
      2'b10:   alu_f = alu_a ^ alu_b;
      default: alu_f = alu_a << 1;
    endcase
  end

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: the controller is free from edge free_at onward; a grant
  // at edge n captures at n+1, counts at n+2 and frees the controller at n+3.
  int edge_n    = 0;
  int free_at   = 0;
  int cap_edge  = -1;
  int done_edge = -1;
  int m_res[2];
  int m_ack[2];
  int m_gnt     = 0;
  int m_last    = 1;
  int m_cnt     = 0;
  int m_sel     = 0;
  int m_a       = 0;
  int m_b       = 0;
  int m_result  = 0;
  bit m_busy    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    int m;
    m = 1 << W;
    case (op)
      0:       return (a + b) % m;
      1:       return (a - b + m) % m;
      2:       return a ^ b;
      default: return (a * 2) % m;
    endcase
  endfunction

  task automatic model_step();
    int win;
    m_ack[0] = 0;
    m_ack[1] = 0;
    if (reset) begin
      m_res[0] = 0; m_res[1] = 0;
      m_sel = 0; m_a = 0; m_b = 0;
      m_last = 1; m_cnt = 0;
      free_at = edge_n + 1; cap_edge = -1; done_edge = -1;
    end else begin
      if (edge_n == cap_edge) begin
        m_res[m_gnt] = m_result;
        m_ack[m_gnt] = 1;
      end
      if (edge_n == done_edge) m_cnt = (m_cnt + 1) % (1 << CW);
      if (edge_n >= free_at && (req0 || req1)) begin
        if (req0 && req1) win = 1 - m_last;
        else              win = req0 ? 0 : 1;
        m_gnt  = win;
        m_last = win;
        m_sel  = (win == 1) ? int'(op1) : int'(op0);
        m_a    = (win == 1) ? int'(a1)  : int'(a0);
        m_b    = (win == 1) ? int'(b1)  : int'(b0);
        m_result  = alu_ref(m_sel, m_a, m_b);
        cap_edge  = edge_n + 1;
        done_edge = edge_n + 2;
        free_at   = edge_n + 3;
      end
    end
    m_busy = (edge_n < free_at - 1);
    edge_n++;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("ack0", ack0, m_ack[0]);
    chk("ack1", ack1, m_ack[1]);
    chk("ack_overlap", ack0 & ack1, 0);
    chk("res0", res0, m_res[0]);
    chk("res1", res1, m_res[1]);
    chk("alu_fun_sel", alu_fun_sel, m_sel);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("busy", busy, m_busy);
    chk("last_grant", last_grant, m_last);
    chk("op_count", op_count, m_cnt);
    if (ack0 || ack1)
      $display("txn cyc=%0d client=%0d res=%0d count=%0d", cyc, ack1 ? 1 : 0,
               ack1 ? res1 : res0, op_count);
  endtask

  task automatic wait_ack(input int k, input string tag, output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      if ((k == 0) ? ack0 : ack1) begin
        at = cyc;
        return;
      end
    end
    chk(tag, 0, 1);
  endtask

  task automatic drive_random();
    bit hold0, hold1;
    hold0 = m_busy && m_gnt == 0 && m_ack[0] == 0;
    hold1 = m_busy && m_gnt == 1 && m_ack[1] == 0;
    req0 = hold0 ? 1'b1 : ($urandom_range(0, 9) < 6);
    req1 = hold1 ? 1'b1 : ($urandom_range(0, 9) < 6);
    op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
    op1 = 2'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    reset = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    int t0, t1, n_acks, prev;
    reset = 1'b1;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    m_res[0] = 0; m_res[1] = 0; m_ack[0] = 0; m_ack[1] = 0;
    run_cycle();
    run_cycle();
    chk("rst_last_grant", last_grant, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // Client 0 alone: 3 + 6 wraps to 1.
    req0 = 1; op0 = 2'b00; a0 = 3; b0 = 6;
    run_cycle();
    chk("tp1_alu_a", alu_a, 3);
    chk("tp1_alu_b", alu_b, 6);
    a0 = 7; b0 = 7;  // must not disturb the operation in flight
    wait_ack(0, "tp1_timeout", t0);
    chk("tp1_res0", res0, 1);
    req0 = 0;
    run_cycle();
    chk("tp1_count", op_count, 1);

    // Client 1 alone: 2 - 5 = 5 mod 8.
    req1 = 1; op1 = 2'b01; a1 = 2; b1 = 5;
    wait_ack(1, "tp2_timeout", t1);
    chk("tp2_res1", res1, 5);
    chk("tp2_res0_kept", res0, 1);
    chk("tp2_last_grant", last_grant, 1);
    req1 = 0;
    run_cycle();

    // Both from reset: client 0 first (5^3=6), then client 1 (6<<1=4).
    reset = 1; run_cycle(); reset = 0;
    req0 = 1; op0 = 2'b10; a0 = 5; b0 = 3;
    req1 = 1; op1 = 2'b11; a1 = 6; b1 = 1;
    wait_ack(0, "tp3_timeout0", t0);
    chk("tp3_res0", res0, 6);
    req0 = 0;
    wait_ack(1, "tp3_timeout1", t1);
    chk("tp3_res1", res1, 4);
    chk("tp3_spacing", t1 - t0, 3);
    req1 = 0;
    run_cycle();

    // Reset during EXEC aborts with no ack.
    req0 = 1; op0 = 2'b00; a0 = 1; b0 = 1;
    run_cycle();
    chk("tp4_busy", busy, 1);
    reset = 1; req0 = 0;
    run_cycle();
    reset = 0;
    chk("tp4_ack0", ack0, 0);
    chk("tp4_res0", res0, 0);
    chk("tp4_res1", res1, 0);
    chk("tp4_alu_a", alu_a, 0);
    chk("tp4_count", op_count, 0);
    chk("tp4_last_grant", last_grant, 1);
    run_cycle();
    chk("tp4_no_late_ack", ack0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      run_cycle();
    end

    // Both held high: strict alternation and counter wrap after 256 ops.
    reset = 1; req0 = 0; req1 = 0;
    run_cycle();
    reset = 0; req0 = 1; req1 = 1;
    n_acks = 0; prev = 1;
    for (int i = 0; i < 800 && n_acks < 256; i++) begin
      op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
      op1 = 2'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      run_cycle();
      if (ack0 || ack1) begin
        chk("alternate", ack1 ? 1 : 0, 1 - prev);
        prev = ack1 ? 1 : 0;
        n_acks++;
        if (n_acks == 8) begin
          run_cycle();
          chk("tp5_count8", op_count, 8);
        end
      end
    end
    chk("wrap_acks", n_acks, 256);
    req0 = 0; req1 = 0;
    run_cycle();
    chk("wrap_count", op_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
